// File: rtl/layer_argmax.sv
// Classifier output stage: after the neuron pipeline settles, snapshots all lanes
// and scans them one per cycle for the signed maximum, reporting index and value.
module layer_argmax #(
    parameter int NUM_IN   = 10,
    parameter int DW       = 8,
    parameter int IDX_W    = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_IN*DW-1:0] act_in,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     class_idx,
    output logic [DW-1:0]        class_val,
    output logic                 all_zero
);

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_IN - 1);

    typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SCAN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DW-1:0]     snap_q [NUM_IN];
    logic [DW-1:0]     snap_d [NUM_IN];
    logic [DW-1:0]     max_q, max_d;
    logic [IDX_W-1:0]  max_idx_q, max_idx_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]  class_idx_q, class_idx_d;
    logic [DW-1:0]     class_val_q, class_val_d;
    logic              all_zero_q, all_zero_d;
    logic              done_q, done_d;
    logic              load_out;
    logic [DW-1:0]     lane_sel;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        snap_d      = snap_q;
        max_d       = max_q;
        max_idx_d   = max_idx_q;
        scan_idx_d  = scan_idx_q;
        class_idx_d = class_idx_q;
        class_val_d = class_val_q;
        all_zero_d  = all_zero_q;
        done_d      = 1'b0;
        load_out    = 1'b0;
        lane_sel    = snap_q[scan_idx_q];

        case (state_q)
            IDLE: begin
                if (start) begin
                    wait_cnt_d = '0;
                    state_d    = (PIPE_LAT == 0) ? CAPTURE : WAIT;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    snap_d[i] = act_in[i*DW +: DW];
                end
                max_d      = act_in[DW-1:0];
                max_idx_d  = '0;
                scan_idx_d = IDX_W'(1);
                if (NUM_IN == 1) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                end else begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Strict greater-than keeps the lowest index on ties.
                if ($signed(lane_sel) > $signed(max_q)) begin
                    max_d     = lane_sel;
                    max_idx_d = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + IDX_W'(1);
                if (scan_idx_q == LAST_IDX) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Results publish on the same edge that enters DONE, including the last lane.
        if (load_out) begin
            class_idx_d = max_idx_d;
            class_val_d = max_d;
            all_zero_d  = max_d[DW-1] || (max_d == '0);
            done_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                snap_q[i] <= '0;
            end
            max_q       <= '0;
            max_idx_q   <= '0;
            scan_idx_q  <= '0;
            class_idx_q <= '0;
            class_val_q <= '0;
            all_zero_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            snap_q      <= snap_d;
            max_q       <= max_d;
            max_idx_q   <= max_idx_d;
            scan_idx_q  <= scan_idx_d;
            class_idx_q <= class_idx_d;
            class_val_q <= class_val_d;
            all_zero_q  <= all_zero_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign class_idx = class_idx_q;
    assign class_val = class_val_q;
    assign all_zero  = all_zero_q;

endmodule

// File: tb/tb_layer_argmax.sv
// Self-checking bench for layer_argmax: a timing/argmax model compared every cycle,
// plus directed scenarios with hand-computed results and done-edge positions.
module tb_layer_argmax;

    localparam int NUM_IN   = 10;
    localparam int DW       = 8;
    localparam int IDX_W    = 4;
    localparam int PIPE_LAT = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [NUM_IN*DW-1:0] act_in = '0;
    logic                 busy;
    logic                 done;
    logic [IDX_W-1:0]     class_idx;
    logic [DW-1:0]        class_val;
    logic                 all_zero;

    layer_argmax #(
        .NUM_IN(NUM_IN), .DW(DW), .IDX_W(IDX_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .act_in(act_in),
        .busy(busy), .done(done), .class_idx(class_idx),
        .class_val(class_val), .all_zero(all_zero)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [NUM_IN*DW-1:0] pack(input int v[NUM_IN]);
        logic [NUM_IN*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_IN; i++) r[i*DW +: DW] = DW'(v[i]);
        return r;
    endfunction

    function automatic int lane_of(input logic [NUM_IN*DW-1:0] v, input int i);
        return int'($signed(v[i*DW +: DW]));
    endfunction

    function automatic int argmax_of(input logic [NUM_IN*DW-1:0] v);
        int best = 0;
        for (int i = 1; i < NUM_IN; i++) begin
            if (lane_of(v, i) > lane_of(v, best)) best = i;
        end
        return best;
    endfunction

    // Model: a run accepted at edge 0 captures at edge PIPE_LAT+1, publishes at
    // edge PIPE_LAT+NUM_IN (visible at the following edge) and frees the block one edge later.
    logic                 m_busy = 1'b0;
    logic                 m_done = 1'b0;
    logic                 m_zero = 1'b1;
    int                   m_t    = 0;
    int                   m_idx  = 0;
    int                   m_val  = 0;
    logic [NUM_IN*DW-1:0] m_snap = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_zero <= 1'b1;
            m_t    <= 0;
            m_idx  <= 0;
            m_val  <= 0;
            m_snap <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_t    <= 0;
                end
            end else begin
                m_t <= m_t + 1;
                if (m_t + 1 == PIPE_LAT + 1) m_snap <= act_in;
                if (m_t + 1 == PIPE_LAT + NUM_IN) begin
                    m_idx  <= argmax_of((NUM_IN == 1) ? act_in : m_snap);
                    m_val  <= lane_of((NUM_IN == 1) ? act_in : m_snap,
                                      argmax_of((NUM_IN == 1) ? act_in : m_snap));
                    m_zero <= lane_of((NUM_IN == 1) ? act_in : m_snap,
                                      argmax_of((NUM_IN == 1) ? act_in : m_snap)) <= 0;
                    m_done <= 1'b1;
                end
                if (m_t + 1 == PIPE_LAT + NUM_IN + 1) m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            checkOutput("busy", int'(busy), int'(m_busy));
            checkOutput("done", int'(done), int'(m_done));
            checkOutput("class_idx", int'(class_idx), m_idx);
            checkOutput("class_val", int'($signed(class_val)), m_val);
            checkOutput("all_zero", int'(all_zero), int'(m_zero));
        end
    end

    // done_ks holds k where done is seen high just before edge k (edge 0 accepts start).
    int done_ks[$];

    task automatic applyStimulus(input logic [NUM_IN*DW-1:0] lanes,
                                 input logic [NUM_IN*DW-1:0] alt,
                                 input int alt_at,
                                 input logic [63:0] start_mask,
                                 input int max_k);
        done_ks.delete();
        @(negedge clk);
        act_in = lanes;
        start  = 1'b1;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            if (done) done_ks.push_back(k);
            start = start_mask[k];
            if (k == alt_at) act_in = alt;
        end
        start = 1'b0;
        for (int w = 0; w < 50 && busy; w++) @(negedge clk);
        checkOutput("return_to_idle", int'(busy), 0);
    endtask

    task automatic checkResult(input string name, input int n_done, input int exp_idx,
                               input int exp_val, input int exp_zero);
        checkOutput({name, "_done_count"}, done_ks.size(), n_done);
        for (int i = 0; i < n_done && i < done_ks.size(); i++) begin
            checkOutput({name, "_done_edge"}, done_ks[i], 14 + 15 * i);
        end
        checkOutput({name, "_idx"}, int'(class_idx), exp_idx);
        checkOutput({name, "_val"}, int'($signed(class_val)), exp_val);
        checkOutput({name, "_all_zero"}, int'(all_zero), exp_zero);
        checkOutput({name, "_model_idx"}, m_idx, exp_idx);
        checkOutput({name, "_model_val"}, m_val, exp_val);
    endtask

    localparam logic [63:0] NO_EXTRA  = 64'h0;
    localparam logic [63:0] EXTRA     = (64'h1 << 2) | (64'h1 << 8) | (64'h1 << 14);
    localparam logic [63:0] HELD      = (64'h1 << 45) - 64'h1;

    initial begin
        int v[NUM_IN];
        logic [NUM_IN*DW-1:0] base;

        $display("[TB] layer_argmax bench start");
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_idx", int'(class_idx), 0);
        checkOutput("reset_val", int'(class_val), 0);
        checkOutput("reset_all_zero", int'(all_zero), 1);
        reset  = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        v = '{5, 12, 127, 3, 0, 0, 9, 100, 1, 2};
        base = pack(v);
        applyStimulus(base, base, 0, NO_EXTRA, 16);
        checkResult("basic", 1, 2, 127, 0);

        // Reset lands mid-scan, between edges 7 and 8.
        v = '{1, 2, 3, 4, 5, 77, 6, 7, 8, 9};
        @(negedge clk);
        act_in = pack(v);
        start  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("midscan_busy", int'(busy), 0);
        checkOutput("midscan_done", int'(done), 0);
        checkOutput("midscan_idx", int'(class_idx), 0);
        checkOutput("midscan_val", int'(class_val), 0);
        checkOutput("midscan_all_zero", int'(all_zero), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        v = '{10, 10, 10, 64, 10, 10, 10, 64, 10, 10};
        base = pack(v);
        applyStimulus(base, base, 0, NO_EXTRA, 16);
        checkResult("tie", 1, 3, 64, 0);

        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        base = pack(v);
        applyStimulus(base, base, 0, NO_EXTRA, 16);
        checkResult("all_zero", 1, 0, 0, 1);

        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
        base = pack(v);
        applyStimulus(base, base, 0, NO_EXTRA, 16);
        checkResult("neg_lane9", 1, 0, 0, 1);

        v = '{0, 0, 0, 0, 50, 0, 0, 0, 0, 0};
        base = pack(v);
        v = '{0, 0, 0, 0, 0, 0, 120, 0, 0, 0};
        applyStimulus(base, pack(v), 5, NO_EXTRA, 16);
        checkResult("late_change", 1, 4, 50, 0);

        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -5};
        base = pack(v);
        applyStimulus(base, base, 0, EXTRA, 16);
        checkResult("busy_starts", 1, 8, 9, 0);

        v = '{-3, -7, -1, -2, -100, -128, -1, -50, -9, -4};
        base = pack(v);
        applyStimulus(base, base, 0, HELD, 46);
        checkResult("held_start", 3, 2, -1, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
